mbox_tx_sched: RTL and testbench

- Round-robin scheduler that shares the single outbound mailbox write channel (mbox_w_*) between NREQ local message sources.
- Each grant covers one complete message: a word stream terminated by a last flag.
- The block sequences the end-of-message done pulse and handles local and peer abort.
- It sits between the requesters (CPU-side FIFOs or DMA engines) and the mailbox APB block, in the aclk domain.

---
 rtl/mbox_tx_sched.sv | 208 ++++++++++++++++++++
 tb/tb_mbox_tx_sched.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mbox_tx_sched.sv
// Round-robin scheduler that multiplexes NREQ message sources onto the single
// outbound mailbox write channel, one whole message per grant.
`timescale 1ns/1ps
module mbox_tx_sched #(
    parameter int unsigned NREQ   = 4,
    parameter int unsigned MAXLEN = 1024
) (
    input  logic                 aclk,
    input  logic                 resetn,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [32*NREQ-1:0]   req_dat,
    input  logic [NREQ-1:0]      req_last,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ-1:0]      req_abort,
    output logic [NREQ-1:0]      grant,
    output logic [NREQ-1:0]      req_done,
    output logic [NREQ-1:0]      req_aborted,
    output logic [31:0]          mbox_w_dat,
    output logic                 mbox_w_valid,
    input  logic                 mbox_w_ready,
    output logic                 mbox_w_done,
    output logic                 mbox_w_abort,
    input  logic                 mbox_r_abort,
    output logic                 err_overlen,
    output logic                 busy
);

    localparam int unsigned CW = $clog2(MAXLEN) + 1;
    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_XFER  = 2'd1,
        ST_DONE  = 2'd2,
        ST_ABORT = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [IW-1:0]   rr_q, rr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            pend_q, pend_d;
    logic            w_done_q, w_done_d;
    logic            w_abort_q, w_abort_d;
    logic [NREQ-1:0] req_done_q, req_done_d;
    logic [NREQ-1:0] req_aborted_q, req_aborted_d;
    logic            err_q, err_d;
    logic            busy_q, busy_d;

    logic            pick_vld;
    logic [IW-1:0]   pick_idx;
    logic [IW-1:0]   rr_next;
    logic            own_valid;
    logic            own_last;
    logic            own_abort;
    logic            beat;
    logic [CW-1:0]   cnt_inc;
    logic            at_max;

    // First requesting index at or above rr_q, wrapping modulo NREQ.
    always_comb begin : rr_pick
        int unsigned idx;
        pick_vld = 1'b0;
        pick_idx = '0;
        idx      = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = 32'(rr_q) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!pick_vld && req_valid[IW'(idx)]) begin
                pick_vld = 1'b1;
                pick_idx = IW'(idx);
            end
        end
    end

    assign rr_next   = (32'(owner_q) == NREQ - 1) ? '0 : owner_q + IW'(1);
    assign own_valid = req_valid[owner_q];
    assign own_last  = req_last[owner_q];
    assign own_abort = req_abort[owner_q];
    assign beat      = (state_q == ST_XFER) && own_valid && mbox_w_ready;
    assign cnt_inc   = cnt_q + CW'(1);
    assign at_max    = (cnt_inc == CW'(MAXLEN));

    // Owner's word stream goes straight through to the mailbox while in XFER.
    always_comb begin
        req_ready    = '0;
        mbox_w_valid = 1'b0;
        mbox_w_dat   = '0;
        if (state_q == ST_XFER) begin
            req_ready[owner_q] = mbox_w_ready;
            mbox_w_valid       = own_valid;
            mbox_w_dat         = req_dat[{owner_q, 5'd0} +: 32];
        end
    end

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        grant_d       = grant_q;
        rr_d          = rr_q;
        cnt_d         = cnt_q;
        pend_d        = pend_q;
        w_done_d      = 1'b0;
        w_abort_d     = 1'b0;
        req_done_d    = '0;
        req_aborted_d = '0;
        err_d         = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // A pending or live peer abort is acknowledged before any new grant.
                if (mbox_r_abort || pend_q) begin
                    state_d   = ST_ABORT;
                    w_abort_d = 1'b1;
                end else if (pick_vld) begin
                    state_d = ST_XFER;
                    owner_d = pick_idx;
                    grant_d = NREQ'(1) << pick_idx;
                end
            end
            ST_XFER: begin
                if (beat) begin
                    cnt_d = cnt_inc;
                end
                if (own_abort || mbox_r_abort) begin
                    state_d       = ST_ABORT;
                    w_abort_d     = 1'b1;
                    req_aborted_d = grant_q;
                    err_d         = beat && !own_last && at_max;
                end else if (beat && own_last) begin
                    state_d    = ST_DONE;
                    w_done_d   = 1'b1;
                    req_done_d = grant_q;
                end else if (beat && at_max) begin
                    state_d       = ST_ABORT;
                    w_abort_d     = 1'b1;
                    req_aborted_d = grant_q;
                    err_d         = 1'b1;
                end
            end
            ST_DONE: begin
                if (mbox_r_abort) begin
                    pend_d = 1'b1;
                end
                rr_d    = rr_next;
                cnt_d   = '0;
                grant_d = '0;
                state_d = ST_IDLE;
            end
            ST_ABORT: begin
                if (grant_q != '0) begin
                    rr_d = rr_next;
                end
                cnt_d   = '0;
                grant_d = '0;
                pend_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= ST_IDLE;
            owner_q       <= '0;
            grant_q       <= '0;
            rr_q          <= '0;
            cnt_q         <= '0;
            pend_q        <= 1'b0;
            w_done_q      <= 1'b0;
            w_abort_q     <= 1'b0;
            req_done_q    <= '0;
            req_aborted_q <= '0;
            err_q         <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            grant_q       <= grant_d;
            rr_q          <= rr_d;
            cnt_q         <= cnt_d;
            pend_q        <= pend_d;
            w_done_q      <= w_done_d;
            w_abort_q     <= w_abort_d;
            req_done_q    <= req_done_d;
            req_aborted_q <= req_aborted_d;
            err_q         <= err_d;
            busy_q        <= busy_d;
        end
    end

    assign grant        = grant_q;
    assign req_done     = req_done_q;
    assign req_aborted  = req_aborted_q;
    assign mbox_w_done  = w_done_q;
    assign mbox_w_abort = w_abort_q;
    assign err_overlen  = err_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_mbox_tx_sched.sv
// Randomized and directed bench for mbox_tx_sched against a cycle-level
// behavioural model of message ownership, beats and end-of-message events.
`timescale 1ns/1ps
module tb_mbox_tx_sched;

    localparam int unsigned NREQ   = 4;
    localparam int unsigned MAXLEN = 4;

    logic                 aclk;
    logic                 resetn;
    logic [NREQ-1:0]      req_valid;
    logic [32*NREQ-1:0]   req_dat;
    logic [NREQ-1:0]      req_last;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ-1:0]      req_abort;
    logic [NREQ-1:0]      grant;
    logic [NREQ-1:0]      req_done;
    logic [NREQ-1:0]      req_aborted;
    logic [31:0]          mbox_w_dat;
    logic                 mbox_w_valid;
    logic                 mbox_w_ready;
    logic                 mbox_w_done;
    logic                 mbox_w_abort;
    logic                 mbox_r_abort;
    logic                 err_overlen;
    logic                 busy;

    mbox_tx_sched #(.NREQ(NREQ), .MAXLEN(MAXLEN)) dut (
        .aclk(aclk), .resetn(resetn),
        .req_valid(req_valid), .req_dat(req_dat), .req_last(req_last),
        .req_ready(req_ready), .req_abort(req_abort), .grant(grant),
        .req_done(req_done), .req_aborted(req_aborted),
        .mbox_w_dat(mbox_w_dat), .mbox_w_valid(mbox_w_valid),
        .mbox_w_ready(mbox_w_ready), .mbox_w_done(mbox_w_done),
        .mbox_w_abort(mbox_w_abort), .mbox_r_abort(mbox_r_abort),
        .err_overlen(err_overlen), .busy(busy)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // Reference model: who owns the channel, words so far, pending end event.
    bit          m_xfer;
    int          m_owner;
    int          m_end;      // 0 none, 1 message done, 2 message aborted
    bit          m_err;
    bit          m_pend;
    int          m_cnt;
    int          m_rr;

    // Requester sources: remaining words, next word, valid held until accepted.
    int          s_left   [NREQ];
    bit          s_nolast [NREQ];
    logic [31:0] s_word   [NREQ];
    bit          s_on     [NREQ];
    bit          gaps_en;

    int              n_done, n_abt, n_err, n_rabt;
    logic [31:0]     beat_log  [$];
    logic [NREQ-1:0] grant_log [$];
    logic [NREQ-1:0] prev_grant;

    task automatic clear_obs();
        n_done = 0; n_abt = 0; n_err = 0; n_rabt = 0;
        beat_log.delete();
        grant_log.delete();
    endtask

    task automatic model_reset();
        m_xfer = 0; m_owner = -1; m_end = 0; m_err = 0; m_pend = 0; m_cnt = 0; m_rr = 0;
        for (int i = 0; i < NREQ; i++) begin
            s_left[i] = 0; s_nolast[i] = 0; s_word[i] = '0; s_on[i] = 0;
        end
        prev_grant = '0;
        req_valid = '0; req_dat = '0; req_last = '0; req_abort = '0; mbox_r_abort = 1'b0;
    endtask

    task automatic start_msg(input int i, input int len, input logic [31:0] base, input bit nolast);
        s_left[i] = len; s_word[i] = base; s_nolast[i] = nolast; s_on[i] = 1;
    endtask

    task automatic check_outputs();
        logic [NREQ-1:0] e_grant;
        logic            live;
        logic            e_valid;
        live    = m_xfer || (m_end != 0);
        e_grant = (live && m_owner >= 0) ? (NREQ'(1) << m_owner) : '0;
        e_valid = m_xfer ? req_valid[m_owner] : 1'b0;
        check("grant",       grant,        e_grant);
        check("busy",        busy,         live);
        check("req_ready",   req_ready,    (m_xfer && mbox_w_ready) ? e_grant : '0);
        check("w_valid",     mbox_w_valid, e_valid);
        check("w_done",      mbox_w_done,  m_end == 1);
        check("w_abort",     mbox_w_abort, m_end == 2);
        check("req_done",    req_done,     (m_end == 1) ? e_grant : '0);
        check("req_aborted", req_aborted,  (m_end == 2) ? e_grant : '0);
        check("err_overlen", err_overlen,  m_err);
        if (e_valid) check("w_dat", mbox_w_dat, req_dat[32*m_owner +: 32]);
    endtask

    task automatic observe();
        if (mbox_w_valid && mbox_w_ready) beat_log.push_back(mbox_w_dat);
        if (grant != '0 && prev_grant == '0) grant_log.push_back(grant);
        prev_grant = grant;
        n_done += int'(mbox_w_done);
        n_abt  += int'(mbox_w_abort);
        n_err  += int'(err_overlen);
        n_rabt += $countones(req_aborted);
    endtask

    task automatic model_step(output logic [NREQ-1:0] acc, output logic [NREQ-1:0] drop);
        acc = '0; drop = '0;
        if (m_end != 0) begin
            if (m_end == 2 && m_owner >= 0) drop[m_owner] = 1'b1;
            if (m_owner >= 0) m_rr = (m_owner + 1) % NREQ;
            if (m_end == 2) m_pend = 0;
            else if (mbox_r_abort) m_pend = 1;
            m_owner = -1; m_end = 0; m_err = 0; m_cnt = 0;
        end else if (m_xfer) begin
            bit beat;
            beat = req_valid[m_owner] && mbox_w_ready;
            if (beat) begin acc[m_owner] = 1'b1; m_cnt++; end
            if (req_abort[m_owner] || mbox_r_abort) begin
                m_end = 2; m_xfer = 0;
                m_err = beat && !req_last[m_owner] && (m_cnt == MAXLEN);
            end else if (beat && req_last[m_owner]) begin
                m_end = 1; m_xfer = 0;
            end else if (beat && m_cnt == MAXLEN) begin
                m_end = 2; m_xfer = 0; m_err = 1;
            end
        end else begin
            if (mbox_r_abort || m_pend) begin
                m_end = 2; m_owner = -1;
            end else begin
                for (int k = 0; k < NREQ; k++) begin
                    int idx;
                    idx = (m_rr + k) % NREQ;
                    if (!m_xfer && req_valid[idx]) begin m_xfer = 1; m_owner = idx; end
                end
            end
        end
    endtask

    task automatic cycle();
        logic [NREQ-1:0] acc, drop;
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]        = s_on[i];
            req_dat[32*i +: 32] = s_word[i];
            req_last[i]         = s_on[i] && !s_nolast[i] && (s_left[i] == 1);
        end
        @(negedge aclk);
        check_outputs();
        observe();
        model_step(acc, drop);
        @(posedge aclk);
        #1;
        req_abort    = '0;
        mbox_r_abort = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (acc[i])  begin s_word[i] = s_word[i] + 32'd1; s_left[i]--; s_on[i] = 0; end
            if (drop[i]) begin s_left[i] = 0; s_on[i] = 0; end
            if (s_left[i] > 0 && !s_on[i] && (!gaps_en || $urandom_range(2) != 0)) s_on[i] = 1;
        end
    endtask

    task automatic run(input int n);
        for (int c = 0; c < n; c++) cycle();
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        model_reset();
        clear_obs();
        repeat (2) @(posedge aclk);
        #1 resetn = 1'b1;
    endtask

    initial begin
        logic [NREQ-1:0] rr_exp [7];
        int              bp     [8];
        bit              fired;

        rr_exp = '{4'b0001, 4'b0100, 4'b0001, 4'b0100, 4'b0001, 4'b0010, 4'b0100};
        bp     = '{1, 1, 0, 0, 1, 1, 1, 1};
        gaps_en      = 0;
        mbox_w_ready = 1'b1;
        resetn       = 1'b0;
        model_reset();
        clear_obs();
        #3;
        check("rst_grant",   grant,        '0);
        check("rst_busy",    busy,         1'b0);
        check("rst_ready",   req_ready,    '0);
        check("rst_valid",   mbox_w_valid, 1'b0);
        check("rst_wdone",   mbox_w_done,  1'b0);
        check("rst_wabort",  mbox_w_abort, 1'b0);
        check("rst_done",    req_done,     '0);
        check("rst_aborted", req_aborted,  '0);
        check("rst_err",     err_overlen,  1'b0);
        do_reset();

        // Single 3-word message from requester 0.
        start_msg(0, 3, 32'hA0, 0);
        run(8);
        check("t1_beats", beat_log.size(), 3);
        for (int i = 0; i < 3 && i < beat_log.size(); i++) check("t1_word", beat_log[i], 32'hA0 + i);
        check("t1_done", n_done, 1);
        check("t1_idle", busy, 1'b0);

        // Round-robin between 0 and 2, then requester 1 joins.
        do_reset();
        fired = 0;
        for (int c = 0; c < 60 && grant_log.size() < 7; c++) begin
            if (s_left[0] == 0) start_msg(0, 1, 32'h100 + c, 0);
            if (s_left[2] == 0) start_msg(2, 1, 32'h200 + c, 0);
            if (grant_log.size() == 5 && !fired) begin start_msg(1, 1, 32'h150, 0); fired = 1; end
            cycle();
        end
        check("t2_ngrants", grant_log.size(), 7);
        for (int i = 0; i < 7 && i < grant_log.size(); i++) check("t2_order", grant_log[i], rr_exp[i]);

        // Backpressure on a 2-word message.
        do_reset();
        start_msg(1, 2, 32'hB0, 0);
        for (int c = 0; c < 8; c++) begin mbox_w_ready = bp[c][0]; cycle(); end
        check("t3_beats", beat_log.size(), 2);
        for (int i = 0; i < 2 && i < beat_log.size(); i++) check("t3_word", beat_log[i], 32'hB0 + i);
        check("t3_done", n_done, 1);
        mbox_w_ready = 1'b1;

        // Over-length message: MAXLEN beats then a forced abort; rr moves to 2.
        do_reset();
        start_msg(1, 5, 32'hC0, 1);
        run(8);
        check("t4_beats",   beat_log.size(), MAXLEN);
        check("t4_err",     n_err,  1);
        check("t4_abort",   n_abt,  1);
        check("t4_aborted", n_rabt, 1);
        check("t4_done",    n_done, 0);
        grant_log.delete();
        start_msg(0, 1, 32'hC8, 0);
        start_msg(2, 1, 32'hC9, 0);
        run(3);
        check("t4_rr", (grant_log.size() > 0) ? grant_log[0] : '0, 4'b0100);

        // Local abort from requester 3 on its 2nd word.
        do_reset();
        fired = 0;
        start_msg(3, 3, 32'hD0, 0);
        for (int c = 0; c < 10; c++) begin
            if (m_xfer && m_cnt == 1 && !fired) begin req_abort = 4'b1000; fired = 1; end
            cycle();
        end
        check("t5a_done",    n_done, 0);
        check("t5a_abort",   n_abt,  1);
        check("t5a_aborted", n_rabt, 1);
        check("t5a_beats",   beat_log.size(), 2);

        // Peer abort while idle: acknowledge only.
        clear_obs();
        mbox_r_abort = 1'b1;
        run(4);
        check("t5b_abort",   n_abt,  1);
        check("t5b_aborted", n_rabt, 0);
        check("t5b_grants",  grant_log.size(), 0);

        // Peer abort coincident with a last beat.
        clear_obs();
        start_msg(0, 1, 32'hE0, 0);
        cycle();
        mbox_r_abort = 1'b1;
        run(4);
        check("t5c_done",  n_done, 0);
        check("t5c_abort", n_abt,  1);
        check("t5c_beats", beat_log.size(), 1);

        // Reset in the middle of a message; rr_ptr must restart at 0.
        do_reset();
        start_msg(2, 1, 32'hF0, 0);
        run(4);
        mbox_w_ready = 1'b0;
        start_msg(1, 4, 32'hF8, 0);
        run(3);
        check("t6_pre_busy", busy, 1'b1);
        #1 resetn = 1'b0;
        #1;
        check("t6_grant", grant,        '0);
        check("t6_busy",  busy,         1'b0);
        check("t6_valid", mbox_w_valid, 1'b0);
        check("t6_ready", req_ready,    '0);
        model_reset();
        clear_obs();
        mbox_w_ready = 1'b1;
        repeat (2) @(posedge aclk);
        #1 resetn = 1'b1;
        start_msg(0, 1, 32'h11, 0);
        start_msg(3, 1, 32'h33, 0);
        run(4);
        check("t6_first", (grant_log.size() > 0) ? grant_log[0] : '0, 4'b0001);

        // Random traffic with gaps, backpressure, local and peer aborts.
        do_reset();
        gaps_en = 1;
        for (int c = 0; c < 3000; c++) begin
            mbox_w_ready = ($urandom_range(3) != 0);
            if ($urandom_range(49) == 0) req_abort = NREQ'(1) << $urandom_range(NREQ - 1);
            mbox_r_abort = ($urandom_range(59) == 0);
            for (int i = 0; i < NREQ; i++) begin
                if (s_left[i] == 0 && $urandom_range(7) == 0) begin
                    int len;
                    len = int'($urandom_range(1, 5));
                    start_msg(i, len, {8'(i), 24'($urandom)}, (len == 5) && ($urandom_range(1) != 0));
                    s_on[i] = 0;
                end
            end
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
